// File: rtl/drlp_pkg.sv
// Shared types and constants for the DRLP image-buffer datapath.
// Holds the controller FSM encoding and the default buffer geometry.
package drlp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int WORDS_PER_ENTRY = 6;

endpackage

// File: rtl/drlp_img_bf_ctrl_if.sv
// Host write channel and PE-array read stream of the image-buffer controller.
// master drives writes and consumes the stream; slave is the controller.
interface drlp_img_bf_ctrl_if
    import drlp_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int TOTAL_DATA_WIDTH = DEF_DATA_WIDTH * WORDS_PER_ENTRY
) ();

    logic                        wr_valid;
    logic                        wr_ready;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [TOTAL_DATA_WIDTH-1:0] wr_data;
    logic                        rd_valid;
    logic                        rd_ready;
    logic [TOTAL_DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/drlp_win_addr_gen.sv
// 2-D window address walker: rows x columns with a row stride.
// Advances one word per i_advance; o_last flags the final word.
module drlp_win_addr_gen
    import drlp_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_advance,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_row_len,
    input  logic [ADDR_WIDTH-1:0] i_num_rows,
    input  logic [ADDR_WIDTH-1:0] i_row_stride,
    output logic [ADDR_WIDTH-1:0] o_cur,
    output logic                  o_last
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] row_len;
    logic [ADDR_WIDTH-1:0] num_rows;
    logic [ADDR_WIDTH-1:0] stride;
    logic [ADDR_WIDTH-1:0] col;
    logic [ADDR_WIDTH-1:0] row;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] cur;
    logic                  row_end;

    assign row_end = (col == row_len - ONE);
    assign o_last  = row_end && (row == num_rows - ONE);
    assign o_cur   = cur;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_len  <= '0;
            num_rows <= '0;
            stride   <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            cur      <= '0;
        end else if (i_load) begin
            row_len  <= i_row_len;
            num_rows <= i_num_rows;
            stride   <= i_row_stride;
            col      <= '0;
            row      <= '0;
            row_base <= i_base_addr;
            cur      <= i_base_addr;
        end else if (i_advance) begin
            if (row_end) begin
                col      <= '0;
                row      <= row + ONE;
                row_base <= row_base + stride;
                cur      <= row_base + stride;
            end else begin
                col <= col + ONE;
                cur <= cur + ONE;
            end
        end
    end

endmodule

// File: rtl/drlp_img_bf_ctrl.sv
// Image-buffer controller: round-robin arbiter between host writes and
// the window read sequencer, plus the registered output stream stage.
module drlp_img_bf_ctrl
    import drlp_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * WORDS_PER_ENTRY
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    drlp_img_bf_ctrl_if.slave           bus,
    input  logic                        i_start,
    input  logic [ADDR_WIDTH-1:0]       i_base_addr,
    input  logic [ADDR_WIDTH-1:0]       i_row_len,
    input  logic [ADDR_WIDTH-1:0]       i_num_rows,
    input  logic [ADDR_WIDTH-1:0]       i_row_stride,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_bf_wr_en,
    output logic [ADDR_WIDTH-1:0]       o_bf_wr_addr,
    output logic [TOTAL_DATA_WIDTH-1:0] o_bf_wr_data,
    output logic                        o_bf_rd_en,
    output logic [ADDR_WIDTH-1:0]       o_bf_rd_addr,
    input  logic [TOTAL_DATA_WIDTH-1:0] i_bf_rd_data
);

    state_t                      state;
    state_t                      state_nxt;
    logic                        rd_valid_q;
    logic [TOTAL_DATA_WIDTH-1:0] rd_data_q;
    logic                        done_q;
    logic                        last_was_wr;

    logic                        can_issue;
    logic                        grant_wr;
    logic                        grant_rd;
    logic                        load;
    logic                        empty_cfg;
    logic                        drain_ok;
    logic                        done_set;
    logic [ADDR_WIDTH-1:0]       cur;
    logic                        last;

    assign empty_cfg = (i_row_len == '0) || (i_num_rows == '0);
    assign drain_ok  = !rd_valid_q || bus.rd_ready;

    // Writes lose only on contention when they also won last time.
    assign grant_wr = i_rst_n && bus.wr_valid
                   && (!can_issue || !last_was_wr);
    assign grant_rd = can_issue && !grant_wr;

    drlp_win_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (load),
        .i_advance    (grant_rd),
        .i_base_addr  (i_base_addr),
        .i_row_len    (i_row_len),
        .i_num_rows   (i_num_rows),
        .i_row_stride (i_row_stride),
        .o_cur        (cur),
        .o_last       (last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_start && !empty_cfg) state_nxt = RUN;
            end
            RUN: begin
                if (grant_rd && last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        done_set  = 1'b0;
        can_issue = 1'b0;
        o_busy    = 1'b0;
        unique case (state)
            IDLE: begin
                load     = i_start;
                done_set = i_start && empty_cfg;
            end
            RUN: begin
                o_busy    = 1'b1;
                can_issue = !rd_valid_q || bus.rd_ready;
            end
            DRAIN: begin
                o_busy   = 1'b1;
                done_set = drain_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_was_wr <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            if (grant_wr || grant_rd) last_was_wr <= grant_wr;
            if (grant_rd) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= i_bf_rd_data;
            end else if (bus.rd_ready) begin
                rd_valid_q <= 1'b0;
            end
            done_q <= done_set;
        end
    end

    assign bus.wr_ready  = grant_wr;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign o_done        = done_q;
    assign o_bf_wr_en    = grant_wr;
    assign o_bf_wr_addr  = grant_wr ? bus.wr_addr : '0;
    assign o_bf_wr_data  = grant_wr ? bus.wr_data : '0;
    assign o_bf_rd_en    = grant_rd;
    assign o_bf_rd_addr  = grant_rd ? cur : '0;

endmodule

// File: tb/tb_drlp_img_bf_ctrl.sv
// Directed bench for drlp_img_bf_ctrl with a behavioural image buffer.
// Hand-computed address/cycle tables per scenario.
module tb_drlp_img_bf_ctrl;
    import drlp_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [11:0] i_base_addr;
    logic [11:0] i_row_len;
    logic [11:0] i_num_rows;
    logic [11:0] i_row_stride;
    logic        o_busy;
    logic        o_done;
    logic        o_bf_wr_en;
    logic [11:0] o_bf_wr_addr;
    logic [47:0] o_bf_wr_data;
    logic        o_bf_rd_en;
    logic [11:0] o_bf_rd_addr;
    logic [47:0] i_bf_rd_data;

    drlp_img_bf_ctrl_if #(
        .ADDR_WIDTH       (12),
        .TOTAL_DATA_WIDTH (48)
    ) bus ();

    drlp_img_bf_ctrl dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .bus          (bus),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_row_len    (i_row_len),
        .i_num_rows   (i_num_rows),
        .i_row_stride (i_row_stride),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_bf_wr_en   (o_bf_wr_en),
        .o_bf_wr_addr (o_bf_wr_addr),
        .o_bf_wr_data (o_bf_wr_data),
        .o_bf_rd_en   (o_bf_rd_en),
        .o_bf_rd_addr (o_bf_rd_addr),
        .i_bf_rd_data (i_bf_rd_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Unwritten entries read back a fixed address-tagged pattern.
    function automatic logic [47:0] pat(input logic [11:0] a);
        return {36'h5A5A5A5A5, a};
    endfunction

    logic [47:0] mem     [4096];
    bit          wr_seen [4096];

    always @(posedge i_clk) begin
        if (o_bf_wr_en) begin
            mem[o_bf_wr_addr]     <= o_bf_wr_data;
            wr_seen[o_bf_wr_addr] <= 1'b1;
        end
    end

    assign i_bf_rd_data = wr_seen[o_bf_rd_addr] ? mem[o_bf_rd_addr]
                                                : pat(o_bf_rd_addr);

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    int          iss_cyc  [$];
    logic [11:0] iss_addr [$];
    logic [47:0] words    [$];
    int          hs_cyc;
    int          done_cyc;
    int          nboth;
    int          nwr;
    logic        busy0;

    task automatic sweep(input logic [11:0] base, input logic [11:0] len,
                         input logic [11:0] rows, input logic [11:0] stride,
                         input bit wr_on, input int stall_at);
        int          cyc;
        int          nacc;
        int          stall_left;
        bit          stalled;
        logic [47:0] held;
        iss_cyc.delete();
        iss_addr.delete();
        words.delete();
        hs_cyc     = -1;
        done_cyc   = -1;
        nboth      = 0;
        nwr        = 0;
        nacc       = 0;
        stall_left = 0;
        stalled    = 0;
        held       = '0;
        busy0      = 1'b0;
        @(negedge i_clk);
        i_start      = 1'b1;
        i_base_addr  = base;
        i_row_len    = len;
        i_num_rows   = rows;
        i_row_stride = stride;
        bus.rd_ready = 1'b1;
        bus.wr_valid = wr_on;
        bus.wr_addr  = 12'h7F0;
        bus.wr_data  = 48'h111111111111;
        @(negedge i_clk);
        i_start = 1'b0;
        cyc = 0;
        while (cyc < 40 && done_cyc < 0) begin
            #1;
            if (cyc == 0) busy0 = o_busy;
            if (o_bf_rd_en) begin
                iss_cyc.push_back(cyc);
                iss_addr.push_back(o_bf_rd_addr);
            end
            if (o_bf_rd_en && o_bf_wr_en) nboth++;
            if (o_bf_wr_en) nwr++;
            if (o_done) begin
                done_cyc = cyc;
                check("busy_at_done", o_busy, 0);
            end
            if (bus.rd_valid && bus.rd_ready) begin
                words.push_back(bus.rd_data);
                hs_cyc = cyc;
                nacc++;
            end
            if (stall_left > 0) begin
                check("stall_valid", bus.rd_valid, 1);
                check("stall_hold", bus.rd_data, held);
                check("stall_no_rd", o_bf_rd_en, 0);
                stall_left--;
            end
            if (!stalled && stall_at > 0 && nacc == stall_at) begin
                stalled    = 1;
                stall_left = 5;
                held       = pat(iss_addr[nacc]);
            end
            @(negedge i_clk);
            bus.rd_ready = (stall_left == 0);
            cyc++;
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b1;
        if (done_cyc < 0) check("done_timeout", 0, 1);
    endtask

    localparam logic [11:0] BASIC_A [6] = '{12'h010, 12'h011, 12'h012,
                                            12'h050, 12'h051, 12'h052};
    localparam int          BP_CYC  [6] = '{0, 1, 2, 8, 9, 10};
    localparam logic [11:0] WRAP_A  [4] = '{12'hFFE, 12'hFFF,
                                            12'h000, 12'h001};

    initial begin
        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_base_addr  = '0;
        i_row_len    = '0;
        i_num_rows   = '0;
        i_row_stride = '0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_wr_en", o_bf_wr_en, 0);
        check("rst_rd_en", o_bf_rd_en, 0);
        i_rst_n = 1'b1;

        // reset in the middle of a sweep, with a word in the output reg
        @(negedge i_clk);
        i_start      = 1'b1;
        i_base_addr  = 12'h010;
        i_row_len    = 12'd3;
        i_num_rows   = 12'd2;
        i_row_stride = 12'h040;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (2) @(negedge i_clk);
        check("mid_pre_valid", bus.rd_valid, 1);
        i_rst_n = 1'b0;
        #1;
        check("mid_busy", o_busy, 0);
        check("mid_rd_valid", bus.rd_valid, 0);
        check("mid_rd_data", bus.rd_data, 0);
        check("mid_rd_en", o_bf_rd_en, 0);
        check("mid_rd_addr", o_bf_rd_addr, 0);
        check("mid_done", o_done, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("post_rst_done", o_done, 0);
            check("post_rst_rd_en", o_bf_rd_en, 0);
            check("post_rst_busy", o_busy, 0);
            @(negedge i_clk);
        end

        // write accepted in the same cycle it is presented
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 12'h020;
        bus.wr_data  = 48'hABCDEF012345;
        #1;
        check("wr_ready", bus.wr_ready, 1);
        check("wr_en", o_bf_wr_en, 1);
        check("wr_addr", o_bf_wr_addr, 12'h020);
        check("wr_data", o_bf_wr_data, 48'hABCDEF012345);
        @(negedge i_clk);
        bus.wr_valid = 1'b0;

        // basic sweep
        sweep(12'h010, 12'd3, 12'd2, 12'h040, 1'b0, 0);
        check("basic_n", iss_addr.size(), 6);
        check("basic_busy", busy0, 1);
        for (int k = 0; k < 6; k++) begin
            check("basic_addr", iss_addr[k], BASIC_A[k]);
            check("basic_cyc", iss_cyc[k], k);
            check("basic_data", words[k], pat(BASIC_A[k]));
        end
        check("basic_hs", hs_cyc, 6);
        check("basic_done", done_cyc, 7);

        // continuous write contention
        sweep(12'h010, 12'd3, 12'd2, 12'h040, 1'b1, 0);
        check("cont_n", iss_addr.size(), 6);
        check("cont_both", nboth, 0);
        check("cont_nwr", nwr, 7);
        for (int k = 0; k < 6; k++) begin
            check("cont_addr", iss_addr[k], BASIC_A[k]);
            check("cont_cyc", iss_cyc[k], 2 * k);
        end
        check("cont_hs", hs_cyc, 11);
        check("cont_done", done_cyc, 12);

        // backpressure after the second word
        sweep(12'h010, 12'd3, 12'd2, 12'h040, 1'b0, 2);
        check("bp_n", iss_addr.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check("bp_cyc", iss_cyc[k], BP_CYC[k]);
            check("bp_data", words[k], pat(BASIC_A[k]));
        end
        check("bp_hs", hs_cyc, 11);
        check("bp_done", done_cyc, 12);

        // address wrap
        sweep(12'hFFE, 12'd4, 12'd1, 12'h000, 1'b0, 0);
        check("wrap_n", iss_addr.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check("wrap_addr", iss_addr[k], WRAP_A[k]);
        end
        check("wrap_done", done_cyc, 5);

        // empty windows
        sweep(12'h100, 12'd0, 12'd3, 12'h001, 1'b0, 0);
        check("zlen_n", iss_addr.size(), 0);
        check("zlen_done", done_cyc, 0);
        check("zlen_busy", busy0, 0);
        sweep(12'h100, 12'd2, 12'd0, 12'h001, 1'b0, 0);
        check("zrow_n", iss_addr.size(), 0);
        check("zrow_done", done_cyc, 0);

        // read back the word written after reset
        sweep(12'h020, 12'd1, 12'd1, 12'h000, 1'b0, 0);
        check("wrrd_n", iss_addr.size(), 1);
        check("wrrd_data", words[0], 48'hABCDEF012345);
        check("wrrd_done", done_cyc, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
